// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the state encoding of the memory arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;
    typedef logic [15:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // One latched downstream request; field order matches the load concatenation.
    typedef struct packed {
        logic          write;
        lc3b_word      address;
        lc3b_mem_wmask byte_enable;
        lc3b_data      wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_req_reg.sv
// Request register of the memory arbiter: loads one master's request on grant and
// holds it for the downstream port until the next grant; synchronous clear.
module mem_arbiter_req_reg
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         write_i,
    input  logic [15:0]  address_i,
    input  logic [15:0]  byte_enable_i,
    input  logic [127:0] wdata_i,
    output logic         write_o,
    output logic [15:0]  address_o,
    output logic [15:0]  byte_enable_o,
    output logic [127:0] wdata_o
);

    arb_req_t req_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            req_q <= '0;
        end else if (load_i) begin
            req_q <= {write_i, address_i, byte_enable_i, wdata_i};
        end
    end

    assign write_o       = req_q.write;
    assign address_o     = req_q.address;
    assign byte_enable_o = req_q.byte_enable;
    assign wdata_o       = req_q.wdata;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / memory stage) to one-slave memory arbiter with registered grant.
// Optional saturating grant/conflict counters are built when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int DMEM_PRIORITY = 0,
    parameter int STATS_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   imem_stb,
    input  logic                   imem_cyc,
    input  logic                   imem_write,
    input  logic [15:0]            imem_address,
    input  logic [15:0]            imem_byte_enable,
    input  logic [127:0]           imem_wdata,
    output logic [127:0]           imem_rdata,
    output logic                   imem_resp,

    input  logic                   dmem_stb,
    input  logic                   dmem_cyc,
    input  logic                   dmem_write,
    input  logic [15:0]            dmem_address,
    input  logic [15:0]            dmem_byte_enable,
    input  logic [127:0]           dmem_wdata,
    output logic [127:0]           dmem_rdata,
    output logic                   dmem_resp,

    output logic                   mem_stb,
    output logic                   mem_cyc,
    output logic                   mem_write,
    output logic [15:0]            mem_address,
    output logic [15:0]            mem_byte_enable,
    output logic [127:0]           mem_wdata,
    input  logic [127:0]           mem_rdata,
    input  logic                   mem_resp,

    output logic [STATS_WIDTH-1:0] stat_igrants,
    output logic [STATS_WIDTH-1:0] stat_dgrants,
    output logic [STATS_WIDTH-1:0] stat_conflicts
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       imem_req, dmem_req;
    logic       grant_i, grant_d;
    logic       busy_i, busy_d, busy;

    logic         req_write;
    logic [15:0]  req_address;
    logic [15:0]  req_byte_enable;
    logic [127:0] req_wdata;

    assign imem_req = imem_stb & imem_cyc;
    assign dmem_req = dmem_stb & dmem_cyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, last_d_q=1 hands the grant to fetch, otherwise to dmem.
                if (imem_req && dmem_req) begin
                    if ((DMEM_PRIORITY != 0) || !last_d_q) begin
                        grant_d = 1'b1;
                    end else begin
                        grant_i = 1'b1;
                    end
                end else begin
                    grant_i = imem_req;
                    grant_d = dmem_req;
                end
                if (grant_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                end else if (grant_i) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mem_arbiter_req_reg u_req_reg (
        .clk           (clk),
        .clr_i         (reset),
        .load_i        (grant_i | grant_d),
        .write_i       (grant_d ? dmem_write       : imem_write),
        .address_i     (grant_d ? dmem_address     : imem_address),
        .byte_enable_i (grant_d ? dmem_byte_enable : imem_byte_enable),
        .wdata_i       (grant_d ? dmem_wdata       : imem_wdata),
        .write_o       (req_write),
        .address_o     (req_address),
        .byte_enable_o (req_byte_enable),
        .wdata_o       (req_wdata)
    );

    assign busy_i = (state_q == BUSY_I);
    assign busy_d = (state_q == BUSY_D);
    assign busy   = busy_i | busy_d;

    // Downstream sees only the latched request, and nothing at all between transactions.
    assign mem_stb         = busy;
    assign mem_cyc         = busy;
    assign mem_write       = busy & req_write;
    assign mem_address     = busy ? req_address     : '0;
    assign mem_byte_enable = busy ? req_byte_enable : '0;
    assign mem_wdata       = busy ? req_wdata       : '0;

    assign imem_resp  = mem_resp & busy_i & imem_cyc;
    assign dmem_resp  = mem_resp & busy_d & dmem_cyc;
    assign imem_rdata = busy_i ? mem_rdata : '0;
    assign dmem_rdata = busy_d ? mem_rdata : '0;

`ifdef MEM_ARBITER_STATS_EN
    logic [2:0]               stat_inc;
    logic [3*STATS_WIDTH-1:0] stat_flat;

    assign stat_inc = {(state_q == IDLE) & imem_req & dmem_req, grant_d, grant_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [STATS_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (stat_inc[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stat_flat[gi*STATS_WIDTH +: STATS_WIDTH] = cnt_q;
    end

    assign stat_igrants   = stat_flat[0*STATS_WIDTH +: STATS_WIDTH];
    assign stat_dgrants   = stat_flat[1*STATS_WIDTH +: STATS_WIDTH];
    assign stat_conflicts = stat_flat[2*STATS_WIDTH +: STATS_WIDTH];
`else
    assign stat_igrants   = '0;
    assign stat_dgrants   = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-level model of grant ownership, round-robin order and counters.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam logic [127:0] DEADBEEF = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
`ifdef MEM_ARBITER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic imem_stb, imem_cyc, imem_write, imem_resp;
    logic [15:0] imem_address, imem_byte_enable;
    logic [127:0] imem_wdata, imem_rdata;
    logic dmem_stb, dmem_cyc, dmem_write, dmem_resp;
    logic [15:0] dmem_address, dmem_byte_enable;
    logic [127:0] dmem_wdata, dmem_rdata;
    logic mem_stb, mem_cyc, mem_write, mem_resp;
    logic [15:0] mem_address, mem_byte_enable;
    logic [127:0] mem_wdata, mem_rdata;
    logic [SW-1:0] stat_igrants, stat_dgrants, stat_conflicts;

    always #5 clk = ~clk;

    mem_arbiter #(.DMEM_PRIORITY(0), .STATS_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .imem_stb(imem_stb), .imem_cyc(imem_cyc), .imem_write(imem_write),
        .imem_address(imem_address), .imem_byte_enable(imem_byte_enable),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_stb(dmem_stb), .dmem_cyc(dmem_cyc), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_byte_enable(dmem_byte_enable),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_stb(mem_stb), .mem_cyc(mem_cyc), .mem_write(mem_write),
        .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .stat_igrants(stat_igrants), .stat_dgrants(stat_dgrants), .stat_conflicts(stat_conflicts)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the memory, who wins the next tie, the latched request.
    int           owner = 0;            // 0 = nobody, 1 = imem, 2 = dmem
    bit           imem_next = 1'b0;
    logic         m_write;
    logic [15:0]  m_addr, m_be;
    logic [127:0] m_wdata;
    int           n_ig = 0, n_dg = 0, n_cf = 0;
    int           grant_log[$];
    bit           e_ir, e_dr;
    bit           ia, da;

    logic         s_mem_stb, s_mem_write, s_imem_resp, s_dmem_resp;
    logic [15:0]  s_mem_address;
    logic [127:0] s_dmem_rdata;
    logic [SW-1:0] s_stat_dgrants;

    function automatic int sat(input int n);
        return (n > SMAX) ? SMAX : n;
    endfunction

    task automatic step();
        bit ireq, dreq, win_d;
        @(negedge clk);
        ireq = imem_stb & imem_cyc;
        dreq = dmem_stb & dmem_cyc;
        e_ir = mem_resp && (owner == 1) && imem_cyc;
        e_dr = mem_resp && (owner == 2) && dmem_cyc;
        check("mem_stb", mem_stb, owner != 0);
        check("mem_cyc", mem_cyc, owner != 0);
        if (owner != 0) begin
            check("mem_write", mem_write, m_write);
            check("mem_address", mem_address, m_addr);
            check("mem_byte_enable", mem_byte_enable, m_be);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("imem_resp", imem_resp, e_ir);
        check("dmem_resp", dmem_resp, e_dr);
        check("imem_rdata", imem_rdata, (owner == 1) ? mem_rdata : 128'd0);
        check("dmem_rdata", dmem_rdata, (owner == 2) ? mem_rdata : 128'd0);
        check("stat_igrants", stat_igrants, STATS_ON ? sat(n_ig) : 0);
        check("stat_dgrants", stat_dgrants, STATS_ON ? sat(n_dg) : 0);
        check("stat_conflicts", stat_conflicts, STATS_ON ? sat(n_cf) : 0);
        s_mem_stb      = mem_stb;
        s_mem_write    = mem_write;
        s_mem_address  = mem_address;
        s_imem_resp    = imem_resp;
        s_dmem_resp    = dmem_resp;
        s_dmem_rdata   = dmem_rdata;
        s_stat_dgrants = stat_dgrants;
        if (reset) begin
            owner = 0; imem_next = 1'b0; n_ig = 0; n_dg = 0; n_cf = 0;
        end else if (owner != 0) begin
            if (mem_resp) owner = 0;
        end else begin
            if (ireq && dreq) n_cf++;
            if (ireq || dreq) begin
                win_d = dreq && !(ireq && imem_next);
                owner = win_d ? 2 : 1;
                {m_write, m_addr, m_be, m_wdata} = win_d ?
                    {dmem_write, dmem_address, dmem_byte_enable, dmem_wdata} :
                    {imem_write, imem_address, imem_byte_enable, imem_wdata};
                imem_next = win_d;
                if (win_d) n_dg++; else n_ig++;
                grant_log.push_back(owner);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_stb = 0; imem_cyc = 0; imem_write = 0; imem_address = '0; imem_byte_enable = '0; imem_wdata = '0;
        dmem_stb = 0; dmem_cyc = 0; dmem_write = 0; dmem_address = '0; dmem_byte_enable = '0; dmem_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        step();
        check("reset_addr", s_mem_address, 16'h0000);

        // Lone dmem read from a single-cycle memory.
        dmem_stb = 1; dmem_cyc = 1; dmem_address = 16'h1230; dmem_byte_enable = 16'hFFFF;
        step();
        check("t1_req_cycle_stb", s_mem_stb, 1'b0);
        mem_resp = 1; mem_rdata = DEADBEEF;
        step();
        check("t1_stb", s_mem_stb, 1'b1);
        check("t1_addr", s_mem_address, 16'h1230);
        check("t1_dresp", s_dmem_resp, 1'b1);
        check("t1_rdata", s_dmem_rdata, DEADBEEF);
        check("t1_iresp", s_imem_resp, 1'b0);
        dmem_stb = 0; dmem_cyc = 0;
        step();
        check("t1_resp_once", s_dmem_resp, 1'b0);

        // Simultaneous requests, twice: round-robin order starting with dmem.
        do_reset();
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            idle_inputs();
            imem_stb = 1; imem_cyc = 1; imem_address = 16'h0100 + 16'(r);
            dmem_stb = 1; dmem_cyc = 1; dmem_address = 16'h0200 + 16'(r);
            mem_resp = 1; mem_rdata = 128'h55;
            for (int k = 0; k < 8 && (imem_cyc || dmem_cyc); k++) begin
                step();
                if (e_ir) begin imem_stb = 0; imem_cyc = 0; end
                if (e_dr) begin dmem_stb = 0; dmem_cyc = 0; end
            end
        end
        check("t2_ngrants", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check("t2_order", grant_log[i], (i % 2 == 0) ? 2 : 1);

        // dmem write held through a 5-cycle stall while the master scribbles its address.
        idle_inputs();
        dmem_stb = 1; dmem_cyc = 1; dmem_write = 1; dmem_address = 16'h0040;
        dmem_byte_enable = 16'h0003; dmem_wdata = {4{$urandom}};
        step();
        dmem_address = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_addr", s_mem_address, 16'h0040);
            check("t3_write", s_mem_write, 1'b1);
        end
        mem_resp = 1;
        step();
        check("t3_resp", s_dmem_resp, 1'b1);
        idle_inputs();
        step();

        // imem aborts during a 4-cycle stall.
        imem_stb = 1; imem_cyc = 1; imem_address = 16'h0777;
        step();
        step();
        step();
        imem_stb = 0; imem_cyc = 0;
        step();
        check("t4_iresp_drop", s_imem_resp, 1'b0);
        mem_resp = 1;
        step();
        check("t4_iresp_end", s_imem_resp, 1'b0);
        check("t4_still_busy", s_mem_stb, 1'b1);
        mem_resp = 0;
        step();
        check("t4_idle", s_mem_stb, 1'b0);

        // Reset during BUSY_D, memory acks in the following cycle.
        dmem_stb = 1; dmem_cyc = 1; dmem_address = 16'h2222;
        step();
        step();
        reset = 1;
        step();
        reset = 0; mem_resp = 1; mem_rdata = DEADBEEF;
        step();
        check("t5_dresp", s_dmem_resp, 1'b0);
        check("t5_iresp", s_imem_resp, 1'b0);
        check("t5_stb", s_mem_stb, 1'b0);
        check("t5_addr", s_mem_address, 16'h0000);
        check("t5_rdata", s_dmem_rdata, 128'd0);

        // 20 back-to-back dmem grants saturate the 4-bit grant counter.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            dmem_stb = 1; dmem_cyc = 1; dmem_address = 16'(k);
            step();
            mem_resp = 1;
            step();
            idle_inputs();
            step();
        end
        check("t6_dgrants", s_stat_dgrants, STATS_ON ? 4'd15 : 4'd0);

        // Random traffic: requests, aborts, stray stb, random stalls, occasional reset.
        ia = 0; da = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!ia) ia = ($urandom_range(0, 2) == 0); else if ($urandom_range(0, 15) == 0) ia = 0;
            if (!da) da = ($urandom_range(0, 2) == 0); else if ($urandom_range(0, 15) == 0) da = 0;
            imem_cyc = ia; imem_stb = ia | 1'($urandom_range(0, 1));
            dmem_cyc = da; dmem_stb = da | 1'($urandom_range(0, 1));
            imem_write = ($urandom_range(0, 7) == 0);
            dmem_write = 1'($urandom_range(0, 1));
            imem_address = 16'($urandom); dmem_address = 16'($urandom);
            imem_byte_enable = 16'($urandom); dmem_byte_enable = 16'($urandom);
            imem_wdata = {4{$urandom}}; dmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_resp = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (e_ir) ia = 0;
            if (e_dr) da = 0;
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
